ibex_trace_stream_ctrl: RTL and testbench

- Captures Ibex RVFI retirement records into a small record FIFO.
- Serialises each record as four 32-bit beats onto a valid/ready trace stream for an off-core trace sink.
- Throttles the core through fetch_enable when the FIFO approaches full, so that retirement tracing is lossless under sink backpressure.
- Sits between the SoC fetch-enable source, the core's RVFI outputs and the trace sink.

---
 rtl/ibex_trace_stream_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ibex_trace_stream_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_trace_stream_ctrl.sv
// rtl/ibex_trace_stream_ctrl.sv - RVFI retirement capture, 4-beat trace serialiser and fetch throttle
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   fetch_enable_i/_o         multi-bit fetch enable in from SoC, out to core (registered)
//   trace_en_i                enables capture and throttling
//   clr_i                     clears overflow_o and drop_cnt_o
//   rvfi_*                    core retirement record
//   trace_valid_o/ready_i     beat handshake towards the trace sink
//   trace_data_o/last_o       beat payload, last marks beat 3 of a record
//   overflow_o, drop_cnt_o    sticky drop flag and saturating drop counter
module ibex_trace_stream_ctrl #(
    parameter int unsigned Depth         = 4,
    parameter int unsigned ThrottleLevel = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  fetch_enable_i,
    output logic [3:0]  fetch_enable_o,
    input  logic        trace_en_i,
    input  logic        clr_i,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_intr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    output logic        trace_valid_o,
    input  logic        trace_ready_i,
    output logic [31:0] trace_data_o,
    output logic        trace_last_o,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [3:0] IbexMuBiOn  = 4'b0101;
    localparam logic [3:0] IbexMuBiOff = 4'b1010;

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC    = CW'(Depth);
    localparam logic [CW-1:0] ThrottleC = CW'(ThrottleLevel);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_B3
    } state_e;

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic          last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic          overflow_q;
    logic [15:0]   drop_cnt_q;
    logic [3:0]    fetch_q, fetch_d;

    logic [31:0] mem_pc    [Depth];
    logic [31:0] mem_insn  [Depth];
    logic [31:0] mem_wdata [Depth];
    logic [31:0] mem_meta  [Depth];

    logic        push_req, push_ok, drop, hs, pop;
    logic [31:0] push_meta, next_pc;

    // Only the low 16 bits of the retirement order travel in the record.
    logic unused_order;
    assign unused_order = ^rvfi_order[63:16];

    assign push_meta = {rvfi_order[15:0], 8'h00, rvfi_trap, rvfi_intr, 1'b0, rvfi_rd_addr};

    assign hs       = valid_q & trace_ready_i;
    assign pop      = (state_q == S_B3) & hs;
    assign push_req = rvfi_valid & trace_en_i;
    // A full FIFO still accepts when the head record is freed on this edge.
    assign push_ok  = push_req & ((count_q < DepthC) | pop);
    assign drop     = push_req & ~push_ok;
    assign count_d  = count_q + CW'(push_ok) - CW'(pop);

    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    // With one record left, the only record after the pop is the one being
    // written this edge, so its PC is taken straight from the RVFI inputs.
    assign next_pc = (count_q == CW'(1)) ? rvfi_pc_rdata : mem_pc[rd_ptr_nxt];

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_B0;
                    valid_d = 1'b1;
                    data_d  = mem_pc[rd_ptr_q];
                    last_d  = 1'b0;
                end
            end
            S_B0: if (hs) begin
                state_d = S_B1;
                data_d  = mem_insn[rd_ptr_q];
            end
            S_B1: if (hs) begin
                state_d = S_B2;
                data_d  = mem_wdata[rd_ptr_q];
            end
            S_B2: if (hs) begin
                state_d = S_B3;
                data_d  = mem_meta[rd_ptr_q];
                last_d  = 1'b1;
            end
            S_B3: if (hs) begin
                last_d = 1'b0;
                if (count_d != '0) begin
                    state_d = S_B0;
                    data_d  = next_pc;
                end else begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        fetch_d = IbexMuBiOn;
        if ((fetch_enable_i != IbexMuBiOn) || (trace_en_i && (count_d >= ThrottleC))) begin
            fetch_d = IbexMuBiOff;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            fetch_q    <= IbexMuBiOff;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            fetch_q <= fetch_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_nxt;
            if (clr_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_pc[wr_ptr_q]    <= rvfi_pc_rdata;
            mem_insn[wr_ptr_q]  <= rvfi_insn;
            mem_wdata[wr_ptr_q] <= rvfi_rd_wdata;
            mem_meta[wr_ptr_q]  <= push_meta;
        end
    end

    assign fetch_enable_o = fetch_q;
    assign trace_valid_o  = valid_q;
    assign trace_data_o   = data_q;
    assign trace_last_o   = last_q;
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_ibex_trace_stream_ctrl.sv
// tb/tb_ibex_trace_stream_ctrl.sv - directed self-checking bench for ibex_trace_stream_ctrl
module tb_ibex_trace_stream_ctrl;

    localparam logic [3:0] MUBI_ON  = 4'b0101;
    localparam logic [3:0] MUBI_OFF = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fetch_enable_i;
    logic [3:0]  fetch_enable_o;
    logic        trace_en_i;
    logic        clr_i;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_beats [16];

    always #5 clk = ~clk;

    ibex_trace_stream_ctrl #(.Depth(4), .ThrottleLevel(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fetch_enable_i (fetch_enable_i),
        .fetch_enable_o (fetch_enable_o),
        .trace_en_i     (trace_en_i),
        .clr_i          (clr_i),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_intr      (rvfi_intr),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_data_o   (trace_data_o),
        .trace_last_o   (trace_last_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    function automatic logic [31:0] meta_word(input logic [15:0] order, input logic trap,
                                              input logic intr, input logic [4:0] rd);
        return {order, 8'h00, trap, intr, 1'b0, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one retirement for exactly one clock edge.
    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [15:0] order, input logic trap,
                          input logic intr);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_insn     = insn;
        rvfi_rd_wdata = wdata;
        rvfi_rd_addr  = rd;
        rvfi_order    = {48'hABCD_1234_5678, order};
        rvfi_trap     = trap;
        rvfi_intr     = intr;
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({trace_valid_o, trace_last_o, trace_data_o, overflow_o, drop_cnt_o} !== 51'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h ovf=%b drop=%h, required all zero",
                     trace_valid_o, trace_last_o, trace_data_o, overflow_o, drop_cnt_o);
        end
        tests_run++;
        if (fetch_enable_o !== MUBI_OFF) begin
            tests_failed++;
            $display("FAIL reset_fetch: got %h required %h", fetch_enable_o, MUBI_OFF);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (fetch_enable_o !== MUBI_ON) begin
            tests_failed++;
            $display("FAIL reset_release_fetch: got %h required %h", fetch_enable_o, MUBI_ON);
        end
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_empty_valid: got %b required 0", trace_valid_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp [4];
        exp[0] = 32'h100; exp[1] = 32'h00500093; exp[2] = 32'h5; exp[3] = 32'h00070001;
        trace_ready_i = 1'b1;
        retire(32'h100, 32'h00500093, 32'h5, 5'd1, 16'd7, 1'b0, 1'b0);
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency: valid=%b one cycle after retire, required 0", trace_valid_o);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            tests_run++;
            if ({trace_valid_o, trace_data_o, trace_last_o} !== {1'b1, exp[b], (b == 3)}) begin
                tests_failed++;
                $display("FAIL single_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         b, trace_valid_o, trace_data_o, trace_last_o, exp[b], (b == 3));
            end
        end
        tick();
        tests_run++;
        if ({trace_valid_o, trace_last_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_idle: valid=%b last=%b, required 0 0", trace_valid_o, trace_last_o);
        end
    endtask

    task automatic test_backpressure();
        trace_ready_i = 1'b1;
        retire(32'h200, 32'h11111111, 32'h22222222, 5'd3, 16'h1234, 1'b1, 1'b0);
        tick();
        tick();
        tests_run++;
        if ({trace_valid_o, trace_data_o} !== {1'b1, 32'h11111111}) begin
            tests_failed++;
            $display("FAIL bp_beat1: valid=%b data=%h, required 1 11111111", trace_valid_o, trace_data_o);
        end
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if ({trace_valid_o, trace_data_o, trace_last_o} !== {1'b1, 32'h11111111, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: valid=%b data=%h last=%b, required 1 11111111 0",
                         i, trace_valid_o, trace_data_o, trace_last_o);
            end
        end
        trace_ready_i = 1'b1;
        tick();
        tests_run++;
        if (trace_data_o !== 32'h22222222) begin
            tests_failed++;
            $display("FAIL bp_beat2: data=%h required 22222222", trace_data_o);
        end
        tick();
        tests_run++;
        if ({trace_data_o, trace_last_o} !== {32'h12340083, 1'b1}) begin
            tests_failed++;
            $display("FAIL bp_beat3: data=%h last=%b, required 12340083 1", trace_data_o, trace_last_o);
        end
        tick();
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle: valid=%b required 0", trace_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        trace_ready_i = 1'b1;
        retire(32'h400, 32'h44444444, 32'h4, 5'd4, 16'h0040, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if ({trace_valid_o, trace_last_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_first_last: valid=%b last=%b, required 1 1", trace_valid_o, trace_last_o);
        end
        retire(32'h500, 32'h55555555, 32'h5, 5'd5, 16'h0050, 1'b0, 1'b1);
        tests_run++;
        if ({trace_valid_o, trace_data_o, trace_last_o} !== {1'b1, 32'h500, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_no_bubble: valid=%b data=%h last=%b, required 1 00000500 0",
                     trace_valid_o, trace_data_o, trace_last_o);
        end
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if ({trace_data_o, trace_last_o} !== {32'h00500045, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_second_meta: data=%h last=%b, required 00500045 1", trace_data_o, trace_last_o);
        end
        tick();
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: valid=%b required 0", trace_valid_o);
        end
    endtask

    task automatic test_throttle();
        trace_ready_i = 1'b0;
        retire(32'h600, 32'h6, 32'h6, 5'd6, 16'h0006, 1'b0, 1'b0);
        tests_run++;
        if (fetch_enable_o !== MUBI_ON) begin
            tests_failed++;
            $display("FAIL thr_one_record: fetch=%h required %h", fetch_enable_o, MUBI_ON);
        end
        retire(32'h700, 32'h7, 32'h7, 5'd7, 16'h0007, 1'b0, 1'b0);
        tests_run++;
        if (fetch_enable_o !== MUBI_OFF) begin
            tests_failed++;
            $display("FAIL thr_two_records: fetch=%h required %h", fetch_enable_o, MUBI_OFF);
        end
        trace_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (fetch_enable_o !== MUBI_OFF) begin
            tests_failed++;
            $display("FAIL thr_hold_off: fetch=%h required %h", fetch_enable_o, MUBI_OFF);
        end
        tick();
        tests_run++;
        if ({fetch_enable_o, trace_data_o} !== {MUBI_ON, 32'h700}) begin
            tests_failed++;
            $display("FAIL thr_release: fetch=%h data=%h, required %h 00000700",
                     fetch_enable_o, trace_data_o, MUBI_ON);
        end
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if ({trace_valid_o, fetch_enable_o} !== {1'b0, MUBI_ON}) begin
            tests_failed++;
            $display("FAIL thr_drained: valid=%b fetch=%h, required 0 %h", trace_valid_o, fetch_enable_o, MUBI_ON);
        end
    endtask

    task automatic test_overflow();
        trace_ready_i = 1'b0;
        for (int r = 0; r < 6; r++) begin
            retire(32'h1000 + r, 32'hA0000000 + r, 32'hB0000000 + r, 5'(r), 16'(32'h10 + r), 1'b0, r[0]);
            if (r < 4) begin
                exp_beats[4*r]   = 32'h1000 + r;
                exp_beats[4*r+1] = 32'hA0000000 + r;
                exp_beats[4*r+2] = 32'hB0000000 + r;
                exp_beats[4*r+3] = meta_word(16'(32'h10 + r), 1'b0, r[0], 5'(r));
            end
        end
        tests_run++;
        if ({overflow_o, drop_cnt_o} !== {1'b1, 16'd2}) begin
            tests_failed++;
            $display("FAIL ovf_count: ovf=%b drop=%0d, required 1 2", overflow_o, drop_cnt_o);
        end
        clr_i = 1'b1;
        retire(32'h1006, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 1'b0);
        clr_i = 1'b0;
        tests_run++;
        if ({overflow_o, drop_cnt_o} !== {1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b drop=%0d, required 0 0", overflow_o, drop_cnt_o);
        end
        trace_ready_i = 1'b1;
        for (int b = 0; b < 16; b++) begin
            tests_run++;
            if ({trace_valid_o, trace_data_o} !== {1'b1, exp_beats[b]}) begin
                tests_failed++;
                $display("FAIL ovf_drain_beat%0d: valid=%b data=%h, required 1 %h",
                         b, trace_valid_o, trace_data_o, exp_beats[b]);
            end
            tick();
        end
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_drain_idle: valid=%b required 0", trace_valid_o);
        end
    endtask

    task automatic test_full_pop_push();
        trace_ready_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            retire(32'h3000 + r, 32'hC0000000 + r, 32'hD0000000 + r, 5'(r + 8), 16'(32'h20 + r), r[0], 1'b0);
            if (r > 0) begin
                exp_beats[4*(r-1)]   = 32'h3000 + r;
                exp_beats[4*(r-1)+1] = 32'hC0000000 + r;
                exp_beats[4*(r-1)+2] = 32'hD0000000 + r;
                exp_beats[4*(r-1)+3] = meta_word(16'(32'h20 + r), r[0], 1'b0, 5'(r + 8));
            end
        end
        exp_beats[12] = 32'h3100;
        exp_beats[13] = 32'hC0000100;
        exp_beats[14] = 32'hD0000100;
        exp_beats[15] = meta_word(16'h0099, 1'b1, 1'b1, 5'd31);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (trace_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_at_b3: last=%b required 1", trace_last_o);
        end
        retire(32'h3100, 32'hC0000100, 32'hD0000100, 5'd31, 16'h0099, 1'b1, 1'b1);
        trace_ready_i = 1'b0;
        tests_run++;
        if ({overflow_o, drop_cnt_o, trace_data_o} !== {1'b0, 16'd0, 32'h3001}) begin
            tests_failed++;
            $display("FAIL full_pop_push: ovf=%b drop=%0d data=%h, required 0 0 00003001",
                     overflow_o, drop_cnt_o, trace_data_o);
        end
        retire(32'h3200, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 1'b0);
        tests_run++;
        if ({overflow_o, drop_cnt_o} !== {1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL full_still_full: ovf=%b drop=%0d, required 1 1", overflow_o, drop_cnt_o);
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        trace_ready_i = 1'b1;
        for (int b = 0; b < 16; b++) begin
            tests_run++;
            if ({trace_valid_o, trace_data_o} !== {1'b1, exp_beats[b]}) begin
                tests_failed++;
                $display("FAIL full_drain_beat%0d: valid=%b data=%h, required 1 %h",
                         b, trace_valid_o, trace_data_o, exp_beats[b]);
            end
            tick();
        end
        tests_run++;
        if (trace_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain_idle: valid=%b required 0", trace_valid_o);
        end
    endtask

    task automatic test_trace_disable();
        trace_en_i = 1'b0;
        trace_ready_i = 1'b0;
        for (int r = 0; r < 3; r++) retire(32'h800 + r, 32'h8, 32'h8, 5'd8, 16'h8, 1'b0, 1'b0);
        tick();
        tests_run++;
        if ({trace_valid_o, fetch_enable_o, overflow_o} !== {1'b0, MUBI_ON, 1'b0}) begin
            tests_failed++;
            $display("FAIL disable_no_capture: valid=%b fetch=%h ovf=%b, required 0 %h 0",
                     trace_valid_o, fetch_enable_o, overflow_o, MUBI_ON);
        end
        trace_en_i = 1'b1;
    endtask

    task automatic test_invalid_fetch();
        fetch_enable_i = 4'b0000;
        tick();
        tests_run++;
        if (fetch_enable_o !== MUBI_OFF) begin
            tests_failed++;
            $display("FAIL invalid_fetch: got %h required %h", fetch_enable_o, MUBI_OFF);
        end
        fetch_enable_i = MUBI_ON;
        tick();
        tests_run++;
        if (fetch_enable_o !== MUBI_ON) begin
            tests_failed++;
            $display("FAIL fetch_restore: got %h required %h", fetch_enable_o, MUBI_ON);
        end
    endtask

    task automatic test_reset_mid();
        trace_ready_i = 1'b0;
        for (int r = 0; r < 3; r++) retire(32'h900 + r, 32'h9, 32'h99 + r, 5'd9, 16'h9, 1'b0, 1'b0);
        trace_ready_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (trace_data_o !== 32'h99) begin
            tests_failed++;
            $display("FAIL rstmid_at_b2: data=%h required 00000099", trace_data_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({trace_valid_o, trace_last_o, trace_data_o, fetch_enable_o} !== {1'b0, 1'b0, 32'h0, MUBI_OFF}) begin
            tests_failed++;
            $display("FAIL rstmid_async: valid=%b last=%b data=%h fetch=%h, required 0 0 0 %h",
                     trace_valid_o, trace_last_o, trace_data_o, fetch_enable_o, MUBI_OFF);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if ({trace_valid_o, fetch_enable_o} !== {1'b0, MUBI_ON}) begin
            tests_failed++;
            $display("FAIL rstmid_fifo_empty: valid=%b fetch=%h, required 0 %h", trace_valid_o, fetch_enable_o, MUBI_ON);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_enable_i = MUBI_ON;
        trace_en_i     = 1'b1;
        clr_i          = 1'b0;
        rvfi_valid     = 1'b0;
        rvfi_order     = '0;
        rvfi_insn      = '0;
        rvfi_trap      = 1'b0;
        rvfi_intr      = 1'b0;
        rvfi_rd_addr   = '0;
        rvfi_rd_wdata  = '0;
        rvfi_pc_rdata  = '0;
        trace_ready_i  = 1'b0;

        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_throttle();
        test_overflow();
        test_full_pop_push();
        test_trace_disable();
        test_invalid_fetch();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
